// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS inter-stage pipeline buffers: default field
// widths, bubble encodings and occupancy codes.
package pipe_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int CTRL_W_DEF  = 15;
    localparam int DATA_W_DEF  = 32;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR   = '0;
    localparam logic [CTRL_W_DEF-1:0]  CTRL_BUBBLE = '0;

    // The buffer state is the occupancy itself, so the code drives the port directly.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single payload+valid register with load and clear; clear wins over load and
// always returns the payload to zero so an empty entry reads as a bubble.
module pipe_entry_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_d;
    logic [W-1:0] q_d;

    always_comb begin
        valid_d = valid;
        q_d     = q;
        if (clear) begin
            valid_d = 1'b0;
            q_d     = '0;
        end else if (load) begin
            valid_d = 1'b1;
            q_d     = d;
        end
    end

    // NOTE: non-blocking assignments in sequential blocks avoid read/write races between flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= valid_d;
            q     <= q_d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage buffer with a 2-entry skid (head + skid) and flush.
// Optional `PIPE_STAGE_STALL_CNT_EN adds a saturating downstream-stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LANES   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSTR_W-1:0]      in_instr,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int PAY_W = INSTR_W + CTRL_W + LANES * DATA_W;

    logic             head_valid, skid_valid;
    logic [PAY_W-1:0] head_q, skid_q, in_pay, head_d;
    logic             head_load, head_clear, skid_load, skid_clear, head_from_skid;
    logic             accept, pop;
    logic             in_ready_q, in_ready_d;
    occ_e             state, state_d;

    assign in_pay = {in_instr, in_ctrl, in_data};
    assign accept = in_valid && in_ready_q;
    assign pop    = head_valid && out_ready;
    assign head_d = head_from_skid ? skid_q : in_pay;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        head_load      = 1'b0;
        head_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        head_from_skid = 1'b0;
        state          = skid_valid ? OCC_FULL : (head_valid ? OCC_ONE : OCC_EMPTY);
        state_d        = state;

        if (flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = OCC_EMPTY;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_load = 1'b1;
                        state_d   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = OCC_FULL;
                    end else if (pop) begin
                        head_clear = 1'b1;
                        state_d    = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = OCC_ONE;
                    end
                end
                default: begin
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = OCC_EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != OCC_FULL);
    end

    pipe_entry_reg #(.W(PAY_W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .clear (head_clear),
        .d     (head_d),
        .valid (head_valid),
        .q     (head_q)
    );

    pipe_entry_reg #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pay),
        .valid (skid_valid),
        .q     (skid_q)
    );

    // Registered so upstream stall logic never sees a path from out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = head_valid;
    assign occupancy = state;
    assign out_instr = head_valid ? head_q[PAY_W-1 -: INSTR_W] : INSTR_W'(NOP_INSTR);
    assign out_ctrl  = head_valid ? head_q[LANES*DATA_W +: CTRL_W] : CTRL_W'(CTRL_BUBBLE);
    assign out_data  = head_valid ? head_q[LANES*DATA_W-1:0] : '0;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: LANES=3 main instance plus a LANES=1 twin.
module tb_pipe_stage_buf;

    localparam int INSTR_W = 32;
    localparam int CTRL_W  = 15;
    localparam int DATA_W  = 32;
    localparam int LANES   = 3;

    typedef struct packed {
        logic [INSTR_W-1:0]      instr;
        logic [CTRL_W-1:0]       ctrl;
        logic [LANES*DATA_W-1:0] data;
    } pay_t;

    logic                    clk = 1'b0;
    logic                    rst_n, flush, in_valid, out_ready;
    logic [INSTR_W-1:0]      in_instr;
    logic [CTRL_W-1:0]       in_ctrl;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_ready, out_valid;
    logic [INSTR_W-1:0]      out_instr;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [LANES*DATA_W-1:0] out_data;
    logic [1:0]              occupancy;

    logic                    in_ready1, out_valid1;
    logic [INSTR_W-1:0]      out_instr1;
    logic [CTRL_W-1:0]       out_ctrl1;
    logic [DATA_W-1:0]       out_data1;
    logic [1:0]              occupancy1;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0]             stall_cnt, stall_cnt1;
    logic [15:0]             m_stall;
`endif

    pay_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   acc;

    always #5 clk = ~clk;

    pipe_stage_buf #(.INSTR_W(INSTR_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    pipe_stage_buf #(.INSTR_W(INSTR_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_instr(in_instr), .in_ctrl(in_ctrl), .in_data(in_data[DATA_W-1:0]),
        .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1),
        .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occupancy1)
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .stall_cnt(stall_cnt1)
`endif
    );

    function automatic pay_t mk(input int n);
        pay_t p;
        p.instr = INSTR_W'(n);
        p.ctrl  = CTRL_W'(n * 3 + 1);
        for (int i = 0; i < LANES; i++) begin
            p.data[i*DATA_W +: DATA_W] = DATA_W'((n << 16) | (32'h1000 + i));
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare 1ns later.
    task automatic step(input bit rst, input bit fl, input bit v, input int n,
                        input bit ordy, output bit accepted);
        pay_t p, h;
        int   sz;
        @(negedge clk);
        p         = mk(n);
        rst_n     = rst;
        flush     = fl;
        in_valid  = v;
        out_ready = ordy;
        in_instr  = p.instr;
        in_ctrl   = p.ctrl;
        in_data   = p.data;
        @(posedge clk);
        accepted = 1'b0;
        sz = sb.size();
        if (!rst) begin
            sb.delete();
`ifdef PIPE_STAGE_STALL_CNT_EN
            m_stall = '0;
`endif
        end else begin
`ifdef PIPE_STAGE_STALL_CNT_EN
            if (sz > 0 && !ordy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
            if (sz > 0 && ordy) void'(sb.pop_front());
            if (fl) begin
                sb.delete();
            end else if (v && sz < 2) begin
                sb.push_back(p);
                accepted = 1'b1;
            end
        end
        #1;
        h = (sb.size() > 0) ? sb[0] : '0;
        check("out_valid", 128'(out_valid), 128'(sb.size() > 0));
        check("in_ready",  128'(in_ready),  128'(sb.size() < 2));
        check("occupancy", 128'(occupancy), 128'(sb.size()));
        check("out_instr", 128'(out_instr), 128'(h.instr));
        check("out_ctrl",  128'(out_ctrl),  128'(h.ctrl));
        check("out_data",  128'(out_data),  128'(h.data));
        check("l1_data",   128'(out_data1), 128'(h.data[DATA_W-1:0]));
        check("l1_occ",    128'(occupancy1), 128'(sb.size()));
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_ctrl = '0; in_data = '0;
`ifdef PIPE_STAGE_STALL_CNT_EN
        m_stall = '0;
`endif
        // Reset held with a pending upstream entry.
        step(0, 0, 1, 'h99, 1, acc);
        step(0, 0, 1, 'h99, 1, acc);
        step(1, 0, 0, 0, 1, acc);

        // Back-to-back streaming.
        for (int n = 1; n <= 8; n++) step(1, 0, 1, n, 1, acc);
        step(1, 0, 0, 0, 1, acc);
        step(1, 0, 0, 0, 1, acc);

        // Backpressure: A, B fill the buffer, C waits.
        step(1, 0, 1, 'hA, 0, acc);
        step(1, 0, 1, 'hB, 0, acc);
        step(1, 0, 1, 'hC, 0, acc);
        step(1, 0, 1, 'hC, 0, acc);
        acc = 1'b0;
        for (int k = 0; k < 6 && !acc; k++) step(1, 0, 1, 'hC, 1, acc);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1, acc);

        // Flush in FULL with an incoming entry and no pop.
        step(1, 0, 1, 'hE, 0, acc);
        step(1, 0, 1, 'hF, 0, acc);
        step(1, 1, 1, 'hD, 0, acc);
        step(1, 0, 0, 0, 1, acc);

        // Flush in FULL with a simultaneous pop.
        step(1, 0, 1, 'h21, 0, acc);
        step(1, 0, 1, 'h22, 0, acc);
        step(1, 1, 1, 'hD, 1, acc);
        step(1, 0, 1, 'h23, 1, acc);
        step(1, 0, 0, 0, 1, acc);

        // Reset mid-operation.
        step(1, 0, 1, 'h31, 0, acc);
        step(1, 0, 1, 'h32, 0, acc);
        step(0, 0, 1, 'h33, 1, acc);
        step(1, 0, 1, 'h34, 0, acc);
        step(1, 0, 0, 0, 1, acc);

`ifdef PIPE_STAGE_STALL_CNT_EN
        // Five stalled cycles from a clean counter, then saturation.
        step(0, 0, 0, 0, 0, acc);
        step(1, 0, 1, 'h41, 0, acc);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, acc);
        check("stall_five", 128'(stall_cnt), 128'(16'd5));
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        m_stall = 16'hFFFD;
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, acc);
        check("stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
        step(1, 1, 0, 0, 0, acc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
